trace_cntrl_mul_acc_sink: RTL and testbench



---
 rtl/trace_cntrl_acc_pkg.sv | 19 +
 rtl/trace_cntrl_vld_shift.sv | 40 ++++
 rtl/trace_cntrl_mul_acc_sink.sv | 171 +++++++++++++++++
 tb/tb_trace_cntrl_mul_acc_sink.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_cntrl_acc_pkg.sv
// Shared types and default widths for the trace multiplier accumulate sink.
package trace_cntrl_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam int DATA_W_DEF  = 32;
    localparam int ACC_W_DEF   = 48;
    localparam int CNT_W_DEF   = 16;
    localparam int MUL_LAT_DEF = 6;

    // Signed limits of the default-width accumulator
    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/trace_cntrl_vld_shift.sv
// Valid shadow of the multiplier pipeline: DEPTH-stage 1-bit shift register
// advancing with the multiplier clock enable, with a synchronous clear.
module trace_cntrl_vld_shift #(
    parameter int DEPTH = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] shadow_reg;
    logic [DEPTH-1:0] shift_in;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign shift_in[gi] = d;
            end else begin : g_body
                assign shift_in[gi] = shadow_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_reg <= '0;
        end else if (clr) begin
            shadow_reg <= '0;
        end else if (ce) begin
            shadow_reg <= shift_in;
        end
    end

    assign q = shadow_reg[DEPTH-1];

endmodule

// File: rtl/trace_cntrl_mul_acc_sink.sv
// Windowed accumulator behind the pipelined trace multiplier, with a
// valid/ready result port. TRACE_CNTRL_ACC_SAT_EN selects saturating adds and out_sat.
module trace_cntrl_mul_acc_sink
    import trace_cntrl_acc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mul_ce,
    input  logic [DATA_W-1:0] mul_p,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef TRACE_CNTRL_ACC_SAT_EN
    ,
    output logic              out_sat
`endif
);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  len_reg, len_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [ACC_W-1:0]  out_data_reg, out_data_next;
    logic              out_valid_reg, out_valid_next;
    logic [ACC_W-1:0]  p_ext, sum_val;
    logic              tail, shadow_clr;

    assign p_ext = {{(ACC_W-DATA_W){mul_p[DATA_W-1]}}, mul_p};

`ifdef TRACE_CNTRL_ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] sum_wide;
    logic           sat_now;
    logic           sat_reg, sat_next;
    logic           out_sat_reg, out_sat_next;

    // One guard bit: overflow whenever it disagrees with the sign bit
    assign sum_wide = {acc_reg[ACC_W-1], acc_reg} + {p_ext[ACC_W-1], p_ext};
    assign sat_now  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign sum_val  = !sat_now ? sum_wide[ACC_W-1:0]
                               : (sum_wide[ACC_W] ? SAT_MIN : SAT_MAX);
    assign out_sat  = out_sat_reg;
`else
    assign sum_val = acc_reg + p_ext;
`endif

    // The shadow freezes with the multiplier so in-flight validity survives DONE
    trace_cntrl_vld_shift #(
        .DEPTH (MUL_LAT)
    ) u_vld_shift (
        .clk   (clk),
        .reset (reset),
        .ce    (mul_ce),
        .clr   (shadow_clr),
        .d     (in_valid),
        .q     (tail)
    );

    assign mul_ce    = (state_reg == ACCUM);
    assign in_ready  = mul_ce;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        count_next     = count_reg;
        acc_next       = acc_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        shadow_clr     = 1'b0;
`ifdef TRACE_CNTRL_ACC_SAT_EN
        sat_next       = sat_reg;
        out_sat_next   = out_sat_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (run) begin
                    len_next   = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
                    count_next = '0;
                    acc_next   = '0;
`ifdef TRACE_CNTRL_ACC_SAT_EN
                    sat_next   = 1'b0;
`endif
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (!run) begin
                    acc_next   = '0;
                    count_next = '0;
                    shadow_clr = 1'b1;
`ifdef TRACE_CNTRL_ACC_SAT_EN
                    sat_next   = 1'b0;
`endif
                    state_next = IDLE;
                end else if (tail) begin
                    if (count_reg == len_reg - CNT_W'(1)) begin
                        out_data_next  = sum_val;
                        out_valid_next = 1'b1;
                        acc_next       = '0;
                        count_next     = '0;
`ifdef TRACE_CNTRL_ACC_SAT_EN
                        out_sat_next   = sat_reg | sat_now;
                        sat_next       = 1'b0;
`endif
                        state_next     = DONE;
                    end else begin
                        acc_next   = sum_val;
                        count_next = count_reg + CNT_W'(1);
`ifdef TRACE_CNTRL_ACC_SAT_EN
                        sat_next   = sat_reg | sat_now;
`endif
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    if (run) begin
                        state_next = ACCUM;
                    end else begin
                        shadow_clr = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            count_reg     <= '0;
            acc_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
`ifdef TRACE_CNTRL_ACC_SAT_EN
            sat_reg       <= 1'b0;
            out_sat_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            count_reg     <= count_next;
            acc_reg       <= acc_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
`ifdef TRACE_CNTRL_ACC_SAT_EN
            sat_reg       <= sat_next;
            out_sat_reg   <= out_sat_next;
`endif
        end
    end

endmodule

// File: tb/tb_trace_cntrl_mul_acc_sink.sv
// Directed bench for trace_cntrl_mul_acc_sink with a ce-gated multiplier pipe model.
module tb_trace_cntrl_mul_acc_sink;

    localparam int MUL_LAT = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] cfg_len;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] prod;
    logic [31:0] mul_p;

    logic        in_ready, mul_ce, out_valid;
    logic [47:0] out_data;
    logic        in_ready_w40, mul_ce_w40, out_valid_w40;
    logic [39:0] out_data_w40;
`ifdef TRACE_CNTRL_ACC_SAT_EN
    logic        out_sat, out_sat_w40;
`endif

    always #5 clk = ~clk;

    trace_cntrl_mul_acc_sink u_dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_ce    (mul_ce),
        .mul_p     (mul_p),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef TRACE_CNTRL_ACC_SAT_EN
        ,
        .out_sat   (out_sat)
`endif
    );

    trace_cntrl_mul_acc_sink #(.ACC_W(40)) u_dut_w40 (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w40),
        .mul_ce    (mul_ce_w40),
        .mul_p     (mul_p),
        .out_data  (out_data_w40),
        .out_valid (out_valid_w40),
        .out_ready (out_ready)
`ifdef TRACE_CNTRL_ACC_SAT_EN
        ,
        .out_sat   (out_sat_w40)
`endif
    );

    // Upstream multiplier model: MUL_LAT ce-gated stages carrying the product
    logic [31:0] p_pipe [MUL_LAT];
    initial for (int k = 0; k < MUL_LAT; k++) p_pipe[k] = 32'h0;
    always @(posedge clk) begin
        if (mul_ce) begin
            p_pipe[0] <= prod;
            for (int k = 1; k < MUL_LAT; k++) p_pipe[k] <= p_pipe[k-1];
        end
    end
    assign mul_p = p_pipe[MUL_LAT-1];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    logic [31:0] prod_q [$];
    bit          vld_q  [$];
    logic [47:0] exp_q  [$];
    logic [39:0] exp40_q[$];
    bit          exp_sat40;

    task automatic clear_q();
        prod_q.delete();
        vld_q.delete();
        exp_q.delete();
        exp40_q.delete();
    endtask

    task automatic push(input logic [31:0] v, input bit vld);
        prod_q.push_back(v);
        vld_q.push_back(vld);
    endtask

    task automatic go_idle();
        run       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Each queued entry is consumed on a cycle with in_ready=1; results are
    // compared as they transfer, optionally stalling the first one.
    task automatic run_seq(input string tag, input int len, input int stall,
                           input int exp_lat, input bit chk40);
        int  i = 0, w = 0, hold = 0, c0 = -1, c1 = -1;
        bit  took;
        run     = 1'b1;
        cfg_len = 16'(len);
        for (int cyc = 0; cyc < 2000 && w < exp_q.size(); cyc++) begin
            if (i < prod_q.size()) begin
                in_valid = vld_q[i];
                prod     = prod_q[i];
            end else begin
                in_valid = 1'b0;
                prod     = 32'hDEAD_BEEF;
            end
            took = in_ready;
            if (took && i == 0 && c0 < 0) c0 = cyc;
            if (out_valid) begin
                if (c1 < 0) c1 = cyc;
                if (w == 0 && hold < stall) begin
                    out_ready = 1'b0;
                    check({tag, "_stall_ce"}, 64'(mul_ce), 64'd0);
                    check({tag, "_stall_rdy"}, 64'(in_ready), 64'd0);
                    check({tag, "_stall_data"}, 64'(out_data), 64'(exp_q[0]));
                    hold++;
                end else begin
                    out_ready = 1'b1;
                    check({tag, "_data"}, 64'(out_data), 64'(exp_q[w]));
`ifdef TRACE_CNTRL_ACC_SAT_EN
                    check({tag, "_sat"}, 64'(out_sat), 64'd0);
`endif
                    if (chk40) begin
                        check({tag, "_data40"}, 64'(out_data_w40), 64'(exp40_q[w]));
`ifdef TRACE_CNTRL_ACC_SAT_EN
                        check({tag, "_sat40"}, 64'(out_sat_w40), 64'(exp_sat40));
`endif
                    end
                    w++;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(negedge clk);
            if (took && i < prod_q.size()) i++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (w < exp_q.size()) check({tag, "_timeout"}, 64'(w), 64'(exp_q.size()));
        check({tag, "_vld_clr"}, 64'(out_valid), 64'd0);
        if (exp_lat > 0) check({tag, "_latency"}, 64'(c1 - c0), 64'(exp_lat));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 1'b0; cfg_len = 16'd0; in_valid = 1'b0;
        out_ready = 1'b0; prod = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_mul_ce", 64'(mul_ce), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Four back-to-back products: 3-5+7+100
        clear_q();
        push(32'd3, 1); push(-32'sd5, 1); push(32'd7, 1); push(32'd100, 1);
        exp_q.push_back(48'd105);
        run_seq("len4", 4, 0, MUL_LAT + 4, 0);
        repeat (3) @(negedge clk);
        check("len4_single", 64'(out_valid), 64'd0);

        // Async reset with three products in flight
        go_idle();
        run = 1'b1; cfg_len = 16'd4; in_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; prod = 32'(k + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("rst_mid_ce_pre", 64'(mul_ce), 64'd1);
        check("rst_mid_data_pre", 64'(out_data), 64'd105);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_data", 64'(out_data), 64'd0);
        check("rst_mid_ce", 64'(mul_ce), 64'd0);
        check("rst_mid_rdy", 64'(in_ready), 64'd0);
        check("rst_mid_vld", 64'(out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_q();
        push(32'd11, 1); push(32'd22, 1);
        exp_q.push_back(48'd33);
        run_seq("rst_new", 2, 0, 0, 0);

        // Bubbles in the valid stream are not counted
        go_idle();
        clear_q();
        push(32'd10, 1); push(32'd999, 0); push(32'd999, 0);
        push(32'd20, 1); push(32'd999, 0); push(32'd30, 1);
        exp_q.push_back(48'd60);
        run_seq("bubble", 3, 0, 0, 0);

        // Back-pressure for 5 cycles while operands keep streaming
        go_idle();
        clear_q();
        push(32'd1, 1); push(32'd2, 1); push(32'd4, 1);
        push(32'd8, 1); push(32'd16, 1); push(32'd32, 1);
        exp_q.push_back(48'd3); exp_q.push_back(48'd12); exp_q.push_back(48'd48);
        run_seq("bp", 2, 5, 0, 0);

        // Zero length acts as one product per window
        go_idle();
        clear_q();
        push(32'hFFFF_FFFF, 1); push(32'd5, 1);
        exp_q.push_back(48'hFFFF_FFFF_FFFF); exp_q.push_back(48'd5);
        run_seq("len0", 0, 0, 0, 0);

        // Abort mid-window discards the partial sum
        go_idle();
        run = 1'b1; cfg_len = 16'd4;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; prod = 32'd500;
            @(negedge clk);
        end
        run = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("abort_ce", 64'(mul_ce), 64'd0);
        check("abort_vld", 64'(out_valid), 64'd0);
        clear_q();
        push(32'd6, 1); push(32'd7, 1);
        exp_q.push_back(48'd13);
        run_seq("abort_new", 2, 0, 0, 0);

        // 512 x 0x7FFFFFFF overflows the 40-bit instance only
        go_idle();
        clear_q();
        for (int k = 0; k < 512; k++) push(32'h7FFF_FFFF, 1);
        exp_q.push_back(48'h00FF_FFFF_FE00);
`ifdef TRACE_CNTRL_ACC_SAT_EN
        exp40_q.push_back(40'h7F_FFFF_FFFF);
        exp_sat40 = 1'b1;
`else
        exp40_q.push_back(40'hFF_FFFF_FE00);
        exp_sat40 = 1'b0;
`endif
        run_seq("ovf", 512, 0, 0, 1);

        go_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
